issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_pkg.sv | 23 ++
 rtl/issue_queue_if.sv | 27 ++
 rtl/iq_entry_ram.sv | 37 +++
 rtl/issue_queue.sv | 138 +++++++++++++
 tb/tb_issue_queue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the in-order issue queue and its register-file neighbour:
// instruction class encodings, field widths and the size defaults.
package issue_queue_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int OPW_DEF   = 6;
  localparam int TYPE_W    = 2;
  localparam int REG_W     = 5;
  localparam int XLEN      = 32;

  typedef enum logic [TYPE_W-1:0] {
    IT_REG   = 2'd0,
    IT_IMM   = 2'd1,
    IT_LOAD  = 2'd2,
    IT_STORE = 2'd3
  } ins_type_e;

  // Packed entry layout, MSB first: {type, op, rd, rs1, rs2, imm, pc}.
  function automatic int entry_width(input int opw);
    return TYPE_W + opw + 3 * REG_W + 2 * XLEN;
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decoder -> issue queue handshake. The decoder is the master and offers one
// decoded instruction per cycle; the queue answers with in_ready.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int OPW = OPW_DEF
);
  logic              in_valid;
  logic [TYPE_W-1:0] in_type;
  logic [OPW-1:0]    in_op;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic              in_ready;

  modport master (
    output in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc,
    output in_ready
  );
endinterface

// File: rtl/iq_entry_ram.sv
// Entry storage for the issue queue: one synchronous write port at the tail,
// a full asynchronous read at the head and a register-index-only read at
// head+1 (only the source indices of the following entry are ever needed).
module iq_entry_ram
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPW   = OPW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int EW   = entry_width(OPW)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [EW-1:0]    wr_data,
  input  logic [PW-1:0]    rd_addr0,
  output logic [EW-1:0]    rd_data0,
  input  logic [PW-1:0]    rd_addr1,
  output logic [REG_W-1:0] rd_rs1,
  output logic [REG_W-1:0] rd_rs2
);

  localparam int RS2_LSB = 2 * XLEN;
  localparam int RS1_LSB = RS2_LSB + REG_W;

  logic [EW-1:0] mem [DEPTH];

  // Storage needs no reset: validity is tracked by the queue's count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_rs1   = mem[rd_addr1][RS1_LSB +: REG_W];
  assign rd_rs2   = mem[rd_addr1][RS2_LSB +: REG_W];

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between decoder and ALU. Entries sit in a circular
// buffer; the head issues when its operands were reported ready (ops_ok, sampled
// one cycle ahead from the regfile via pre_rs1/pre_rs2) and the ALU is free.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  issue_queue_if.slave      dec,
  input  logic              flush,
  input  logic              alu_busy,
  output logic              issue_rdy,
  output logic [TYPE_W-1:0] ins_type,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [REG_W-1:0]  pre_rs1,
  output logic [REG_W-1:0]  pre_rs2,
  input  logic              op1_rdy,
  input  logic              op2_rdy,
  output logic [OPW-1:0]    op,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_width(OPW);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          ops_ok;

  logic          not_empty;
  logic          offer_ok;
  logic          enq;
  logic          issue;

  logic [EW-1:0]     wr_data;
  logic [EW-1:0]     head_data;
  logic [REG_W-1:0]  nxt_rs1;
  logic [REG_W-1:0]  nxt_rs2;

  logic [TYPE_W-1:0] h_type;
  logic [OPW-1:0]    h_op;
  logic [REG_W-1:0]  h_rd;
  logic [REG_W-1:0]  h_rs1;
  logic [REG_W-1:0]  h_rs2;
  logic [XLEN-1:0]   h_imm;
  logic [XLEN-1:0]   h_pc;

  assign not_empty = (count != '0);

  // Acceptance deliberately ignores a same-cycle issue: a full queue refuses.
  assign dec.in_ready = rdy && (count != CNT_FULL);
  assign offer_ok     = dec.in_valid && dec.in_ready;
  assign enq          = offer_ok && !flush;
  assign issue        = rdy && !flush && not_empty && ops_ok && !alu_busy;
  assign issue_rdy    = issue;

  assign wr_data = {dec.in_type, dec.in_op, dec.in_rd, dec.in_rs1, dec.in_rs2,
                    dec.in_imm, dec.in_pc};

  iq_entry_ram #(
    .DEPTH (DEPTH),
    .OPW   (OPW)
  ) u_ram (
    .clk      (clk),
    .wr_en    (enq),
    .wr_addr  (tail),
    .wr_data  (wr_data),
    .rd_addr0 (head),
    .rd_data0 (head_data),
    .rd_addr1 (head + PTR_ONE),
    .rd_rs1   (nxt_rs1),
    .rd_rs2   (nxt_rs2)
  );

  assign {h_type, h_op, h_rd, h_rs1, h_rs2, h_imm, h_pc} = head_data;

  // Head fields are forced to zero while the queue is empty so stale RAM
  // contents never reach the regfile or ALU.
  assign ins_type = not_empty ? h_type : '0;
  assign op       = not_empty ? h_op   : '0;
  assign rd       = not_empty ? h_rd   : '0;
  assign rs1      = not_empty ? h_rs1  : '0;
  assign rs2      = not_empty ? h_rs2  : '0;
  assign imm      = not_empty ? h_imm  : '0;
  assign pc       = not_empty ? h_pc   : '0;

  // Source indices of whichever entry will be head next cycle, so the regfile
  // busy lookup lines up with ops_ok for that entry.
  always_comb begin
    pre_rs1 = '0;
    pre_rs2 = '0;
    if (issue && (count > CNT_ONE)) begin
      pre_rs1 = nxt_rs1;
      pre_rs2 = nxt_rs2;
    end else if (!issue && not_empty) begin
      pre_rs1 = h_rs1;
      pre_rs2 = h_rs2;
    end else if (offer_ok) begin
      pre_rs1 = dec.in_rs1;
      pre_rs2 = dec.in_rs2;
    end
  end

  // Pointer, occupancy and operand-ready state; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      ops_ok <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        ops_ok <= 1'b0;
      end else begin
        ops_ok <= op1_rdy && op2_rdy;
        if (enq)   tail <= tail + PTR_ONE;
        if (issue) head <= head + PTR_ONE;
        if (enq && !issue)      count <= count + CNT_ONE;
        else if (issue && !enq) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int OPW   = 6;

  typedef struct {
    logic [1:0]     ty;
    logic [OPW-1:0] op;
    logic [4:0]     rd;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [31:0]    imm;
    logic [31:0]    pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic flush = 1'b0;
  logic alu_busy = 1'b0;
  logic op1_rdy = 1'b0;
  logic op2_rdy = 1'b0;
  logic issue_rdy;
  logic [1:0] ins_type;
  logic [4:0] rd, rs1, rs2, pre_rs1, pre_rs2;
  logic [OPW-1:0] op;
  logic [31:0] imm, pc;

  issue_queue_if #(.OPW(OPW)) dec ();

  issue_queue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .dec       (dec),
    .flush     (flush),
    .alu_busy  (alu_busy),
    .issue_rdy (issue_rdy),
    .ins_type  (ins_type),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .pre_rs1   (pre_rs1),
    .pre_rs2   (pre_rs2),
    .op1_rdy   (op1_rdy),
    .op2_rdy   (op2_rdy),
    .op        (op),
    .imm       (imm),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t q[$];
  bit   m_ops_ok;
  int   m_head;
  bit   busy [32];
  bit   use_rf;
  bit   commit_v;
  logic [4:0] commit_rd;
  int   dut_issues;

  int checks;
  int passed;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [127:0] pk(input ent_t e);
    return 128'({e.ty, e.op, e.rd, e.rs1, e.rs2, e.imm, e.pc});
  endfunction

  task automatic set_entry(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    dec.in_type = 2'($urandom_range(0, 3));
    dec.in_op   = OPW'($urandom);
    dec.in_rd   = d;
    dec.in_rs1  = s1;
    dec.in_rs2  = s2;
    dec.in_imm  = $urandom;
    dec.in_pc   = $urandom;
  endtask

  task automatic rand_entry();
    set_entry(5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  // One cycle: inputs are already driven (posedge+1); check outputs, clock,
  // then advance the model by the queue rules.
  task automatic step();
    ent_t cur, nh, z;
    bit e_inr, e_iss, e_enq;
    int n;
    z = '{default: '0};
    #1;
    if (use_rf) begin
      op1_rdy = !busy[pre_rs1];
      op2_rdy = !busy[pre_rs2];
    end
    #1;
    n     = q.size();
    e_inr = rdy && (n != DEPTH);
    e_iss = rdy && !flush && (n > 0) && m_ops_ok && !alu_busy;
    e_enq = dec.in_valid && e_inr;
    cur = '{ty: dec.in_type, op: dec.in_op, rd: dec.in_rd, rs1: dec.in_rs1,
            rs2: dec.in_rs2, imm: dec.in_imm, pc: dec.in_pc};
    if (e_iss && n > 1)       nh = q[1];
    else if (!e_iss && n > 0) nh = q[0];
    else if (e_enq)           nh = cur;
    else                      nh = z;
    check("in_ready", 128'(dec.in_ready), 128'(e_inr));
    check("issue_rdy", 128'(issue_rdy), 128'(e_iss));
    check("head_fields", 128'({ins_type, op, rd, rs1, rs2, imm, pc}), (n > 0) ? pk(q[0]) : 128'(0));
    check("pre_rs", 128'({pre_rs1, pre_rs2}), 128'({nh.rs1, nh.rs2}));
    check("count", 128'(dut.count), 128'(n));
    check("head_ptr", 128'(dut.head), 128'(m_head));
    check("tail_ptr", 128'(dut.tail), 128'((m_head + n) % DEPTH));
    if (issue_rdy) dut_issues++;
    @(posedge clk);
    if (commit_v) busy[commit_rd] = 1'b0;
    if (e_iss && q[0].rd != 5'd0) busy[q[0].rd] = 1'b1;
    if (rdy) begin
      if (flush) begin
        q.delete();
        m_ops_ok = 1'b0;
        m_head   = 0;
      end else begin
        m_ops_ok = op1_rdy && op2_rdy;
        if (e_iss) begin
          void'(q.pop_front());
          m_head = (m_head + 1) % DEPTH;
        end
        if (e_enq) q.push_back(cur);
      end
    end
    #1;
  endtask

  task automatic idle();
    dec.in_valid = 1'b0;
    step();
  endtask

  initial begin
    int base;
    checks = 0; passed = 0; dut_issues = 0;
    use_rf = 1'b0; commit_v = 1'b0; commit_rd = '0;
    m_ops_ok = 1'b0; m_head = 0;
    for (int i = 0; i < 32; i++) busy[i] = 1'b0;
    dec.in_valid = 1'b0;
    set_entry('0, '0, '0);

    // reset: everything zero, in_ready follows rdy
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_rdy", 128'(issue_rdy), 128'(0));
    check("rst_in_ready", 128'(dec.in_ready), 128'(0));
    check("rst_head", 128'({ins_type, op, rd, rs1, rs2, imm, pc}), 128'(0));
    check("rst_pre", 128'({pre_rs1, pre_rs2}), 128'(0));
    rdy = 1'b1;
    #1;
    check("rst_in_ready_rdy", 128'(dec.in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single entry, minimum latency
    op1_rdy = 1'b1; op2_rdy = 1'b1;
    dec.in_valid = 1'b1; set_entry(5'd3, 5'd1, 5'd2);
    step();
    idle();
    idle();

    // fill to full with op2 not ready, ninth offer dropped, then drain in order
    op2_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dec.in_valid = 1'b1; rand_entry();
      step();
    end
    check("full_in_ready", 128'(dec.in_ready), 128'(0));
    op2_rdy = 1'b1;
    for (int i = 0; i < 10; i++) idle();

    // dependent pair through a regfile busy model
    use_rf = 1'b1;
    dec.in_valid = 1'b1; set_entry(5'd5, 5'd0, 5'd0); step();
    dec.in_valid = 1'b1; set_entry(5'd6, 5'd5, 5'd0); step();
    for (int i = 0; i < 4; i++) idle();
    commit_v = 1'b1; commit_rd = 5'd5; idle();
    commit_v = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    commit_v = 1'b1; commit_rd = 5'd6; idle();
    commit_v = 1'b0;
    use_rf = 1'b0;

    // flush at count 4 with a concurrent offer
    op1_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dec.in_valid = 1'b1; rand_entry(); step();
    end
    flush = 1'b1; dec.in_valid = 1'b1; rand_entry(); step();
    flush = 1'b0;
    idle();
    idle();

    // rdy low for three cycles with two ready entries
    dec.in_valid = 1'b1; rand_entry(); step();
    dec.in_valid = 1'b1; rand_entry(); step();
    op1_rdy = 1'b1; op2_rdy = 1'b1; alu_busy = 1'b1; idle();
    rdy = 1'b0; alu_busy = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) idle();

    // wrap-around: 20 back-to-back enqueue/issue pairs
    base = dut_issues;
    for (int i = 0; i < 20; i++) begin
      dec.in_valid = 1'b1; rand_entry(); step();
    end
    idle();
    check("wrap_issue_count", 128'(dut_issues - base), 128'(20));

    // random traffic
    for (int i = 0; i < 500; i++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 29) == 0);
      alu_busy     = ($urandom_range(0, 3) == 0);
      op1_rdy      = ($urandom_range(0, 9) < 7);
      op2_rdy      = ($urandom_range(0, 9) < 8);
      dec.in_valid = ($urandom_range(0, 9) < 6);
      rand_entry();
      step();
    end
    rdy = 1'b1; flush = 1'b0; alu_busy = 1'b0;

    // reset asserted mid-operation with a ready head
    op1_rdy = 1'b1; op2_rdy = 1'b1; alu_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec.in_valid = 1'b1; rand_entry(); step();
    end
    dec.in_valid = 1'b0;
    alu_busy = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_issue_rdy", 128'(issue_rdy), 128'(0));
    check("midrst_count", 128'(dut.count), 128'(0));
    check("midrst_head", 128'({ins_type, op, rd, rs1, rs2, imm, pc}), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete(); m_ops_ok = 1'b0; m_head = 0;
    idle();
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
